text_console_buffer: RTL and testbench

TEXT_CONSOLE_BUFFER -- requirements
Module: text_console_buffer

---
 rtl/text_console_pkg.sv | 16 +
 rtl/console_ram.sv | 28 ++
 rtl/text_console_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_text_console_buffer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// Shared types and character constants for the text console buffer.
// Imported by the console storage and the console controller.
package text_console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ALL,
    CLEAR_ROW
  } state_e;

  localparam int LF        = 'h0A;
  localparam int CR        = 'h0D;
  localparam int BS        = 'h08;
  localparam int PRINT_MIN = 'h20;

endpackage

// File: rtl/console_ram.sv
// Character cell storage: simple dual-port, single clock,
// read-first with a registered read port.
module console_ram
  import text_console_pkg::*;
#(
  parameter int DW    = 7,
  parameter int DEPTH = 3600,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Read samples the array before this edge's write lands.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/text_console_buffer.sv
// Scrolling text console: cursor-based stream writes, addressed
// writes, hardware clear and scroll over a circular row buffer.
module text_console_buffer
  import text_console_pkg::*;
#(
  parameter int  COLS   = 80,
  parameter int  ROWS   = 45,
  parameter int  CHAR_W = 7,
  localparam int XW     = $clog2(COLS),
  localparam int YW     = $clog2(ROWS)
) (
  input  logic              clk_125m,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_mode,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              clr_req,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [CHAR_W-1:0] rd_data,
  output logic [XW-1:0]     cursor_x,
  output logic [YW-1:0]     cursor_y,
  output logic              busy,
  output logic              err_range
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [XW-1:0] XMAX     = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX     = YW'(ROWS - 1);
  localparam logic [AW-1:0] CMAX_ALL = AW'(CELLS - 1);
  localparam logic [AW-1:0] CMAX_ROW = AW'(COLS - 1);

  state_e state_q, state_d;

  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XW-1:0]     cx_q, cx_d;
  logic [YW-1:0]     cy_q, cy_d;
  logic [YW-1:0]     top_q, top_d;
  logic              err_q, err_d;
  logic              rd_ok_q;

  logic              accept;
  logic              adv;
  logic              rd_ok;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic [CHAR_W-1:0] wdata;
  logic [CHAR_W-1:0] ram_rdata;

  logic c_print, c_lf, c_cr, c_bs;

  // Logical row to physical row: rotate by top_q within ROWS.
  function automatic logic [YW-1:0] phys_row(
    input logic [YW-1:0] y,
    input logic [YW-1:0] top
  );
    logic [YW:0] s;
    s = {1'b0, y} + {1'b0, top};
    if (s > {1'b0, YMAX}) begin
      s = s - (YW+1)'(ROWS);
    end
    return s[YW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(
    input logic [YW-1:0] prow,
    input logic [XW-1:0] col
  );
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign accept   = wr_valid && wr_ready;

  assign c_print = wr_char >= CHAR_W'(PRINT_MIN);
  assign c_lf    = wr_char == CHAR_W'(LF);
  assign c_cr    = wr_char == CHAR_W'(CR);
  assign c_bs    = wr_char == CHAR_W'(BS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    top_d   = top_q;
    err_d   = 1'b0;
    adv     = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR_ALL;
          cnt_d   = '0;
          cx_d    = '0;
          cy_d    = '0;
          top_d   = '0;
        end else if (accept && wr_mode) begin
          if (wr_x > XMAX || wr_y > YMAX) begin
            err_d = 1'b1;
          end else begin
            we    = 1'b1;
            waddr = cell_addr(phys_row(wr_y, top_q), wr_x);
            wdata = wr_char;
          end
        end else if (accept) begin
          unique case (1'b1)
            c_print: begin
              we    = 1'b1;
              waddr = cell_addr(phys_row(cy_q, top_q), cx_q);
              wdata = wr_char;
              if (cx_q == XMAX) begin
                cx_d = '0;
                adv  = 1'b1;
              end else begin
                cx_d = cx_q + XW'(1);
              end
            end
            c_lf: begin
              cx_d = '0;
              adv  = 1'b1;
            end
            c_cr: cx_d = '0;
            c_bs: begin
              if (cx_q != '0) begin
                cx_d = cx_q - XW'(1);
              end
            end
            default: ;
          endcase
        end
        // Scrolling keeps the cursor on the bottom row and
        // recycles the old top row as the new, blank bottom row.
        if (adv) begin
          if (cy_q != YMAX) begin
            cy_d = cy_q + YW'(1);
          end else begin
            top_d   = (top_q == YMAX) ? '0 : top_q + YW'(1);
            state_d = CLEAR_ROW;
            cnt_d   = '0;
          end
        end
      end
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == CMAX_ALL) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      CLEAR_ROW: begin
        we    = 1'b1;
        waddr = cell_addr(phys_row(YMAX, top_q), cnt_q[XW-1:0]);
        if (cnt_q == CMAX_ROW) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_ok = (rd_x <= XMAX) && (rd_y <= YMAX);
  assign raddr = rd_ok ? cell_addr(phys_row(rd_y, top_q), rd_x) : '0;

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ALL;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      top_q   <= top_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok;
    end
  end

  console_ram #(
    .DW    (CHAR_W),
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_125m),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  // RAM output is unreset; the registered range flag masks it.
  assign rd_data   = rd_ok_q ? ram_rdata : '0;
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;
  assign busy      = state_q != IDLE;
  assign err_range = err_q;

endmodule

// File: tb/tb_text_console_buffer.sv
// Self-checking bench for text_console_buffer against a logical
// screen model that scrolls by shifting rows.
module tb_text_console_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 45;
  localparam int CW   = 7;
  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);

  logic          clk_125m = 1'b0;
  logic          rst_n    = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_mode  = 1'b0;
  logic          clr_req  = 1'b0;
  logic [XW-1:0] wr_x     = '0;
  logic [YW-1:0] wr_y     = '0;
  logic [CW-1:0] wr_char  = '0;
  logic [XW-1:0] rd_x     = '0;
  logic [YW-1:0] rd_y     = '0;
  logic          wr_ready;
  logic          busy;
  logic          err_range;
  logic [CW-1:0] rd_data;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;

  int n_chk  = 0;
  int n_fail = 0;

  logic [CW-1:0] scr [ROWS][COLS];
  int mcx;
  int mcy;

  typedef struct {
    logic mode;
    int   x;
    int   y;
    int   ch;
    int   rx;
    int   ry;
    int   rd;
    int   cx;
    int   cy;
    int   er;
  } vec_t;

  text_console_buffer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CHAR_W (CW)
  ) dut (
    .clk_125m  (clk_125m),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_mode   (wr_mode),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_char   (wr_char),
    .clr_req   (clr_req),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_data   (rd_data),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy),
    .err_range (err_range)
  );

  always #4 clk_125m = ~clk_125m;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) begin
        $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
    end
  endtask

  task automatic m_clear();
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        scr[y][x] = '0;
      end
    end
    mcx = 0;
    mcy = 0;
  endtask

  task automatic m_adv();
    if (mcy < ROWS - 1) begin
      mcy++;
    end else begin
      for (int y = 0; y < ROWS - 1; y++) begin
        for (int x = 0; x < COLS; x++) begin
          scr[y][x] = scr[y+1][x];
        end
      end
      for (int x = 0; x < COLS; x++) begin
        scr[ROWS-1][x] = '0;
      end
    end
  endtask

  task automatic m_write(input logic mode, input int x, input int y,
                         input int c, output int er);
    er = 0;
    if (mode) begin
      if (x < COLS && y < ROWS) scr[y][x] = CW'(c);
      else er = 1;
    end else if (c >= 'h20) begin
      scr[mcy][mcx] = CW'(c);
      if (mcx == COLS - 1) begin
        mcx = 0;
        m_adv();
      end else begin
        mcx++;
      end
    end else if (c == 'h0A) begin
      mcx = 0;
      m_adv();
    end else if (c == 'h0D) begin
      mcx = 0;
    end else if (c == 'h08 && mcx > 0) begin
      mcx--;
    end
  endtask

  function automatic int m_cell(input int x, input int y);
    if (x < COLS && y < ROWS) return int'(scr[y][x]);
    return 0;
  endfunction

  task automatic push(input logic mode, input int x, input int y,
                      input int c, output int er_got, output int er_exp);
    int   n;
    logic rdy;
    @(negedge clk_125m);
    wr_valid = 1'b1;
    wr_mode  = mode;
    wr_x     = XW'(x);
    wr_y     = YW'(y);
    wr_char  = CW'(c);
    n = 0;
    forever begin
      rdy = wr_ready;
      @(posedge clk_125m);
      if (rdy || n > 20000) break;
      n++;
      @(negedge clk_125m);
    end
    #1;
    wr_valid = 1'b0;
    er_got   = int'(err_range);
    if (!rdy) chk("push_timeout", 0, 1);
    m_write(mode, x, y, c, er_exp);
  endtask

  task automatic rd_chk(input string nm, input int x, input int y,
                        input int exp);
    @(negedge clk_125m);
    rd_x = XW'(x);
    rd_y = YW'(y);
    @(posedge clk_125m);
    #1;
    chk(nm, int'(rd_data), exp);
  endtask

  task automatic full_cmp(input string nm);
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        rd_chk(nm, x, y, int'(scr[y][x]));
      end
    end
  endtask

  task automatic check_cursor(input string nm);
    chk({nm, "_cx"}, int'(cursor_x), mcx);
    chk({nm, "_cy"}, int'(cursor_y), mcy);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 10000) begin
      @(negedge clk_125m);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic count_ready_low(output int n);
    n = 0;
    while (!wr_ready && n < 10000) begin
      n++;
      @(negedge clk_125m);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    int   n;
    int   eg;
    int   ee;
    int   r;
    int   r2;
    int   x;
    int   y;
    int   c;
    logic md;

    tbl[0]  = '{1'b0,  0,  0, 'h41,  0,  0, 'h41, 1, 0, 0};
    tbl[1]  = '{1'b0,  0,  0, 'h42,  1,  0, 'h42, 2, 0, 0};
    tbl[2]  = '{1'b0,  0,  0, 'h0A,  1,  0, 'h42, 0, 1, 0};
    tbl[3]  = '{1'b0,  0,  0, 'h43,  0,  1, 'h43, 1, 1, 0};
    tbl[4]  = '{1'b0,  0,  0, 'h08,  1,  1,    0, 0, 1, 0};
    tbl[5]  = '{1'b0,  0,  0, 'h08,  0,  1, 'h43, 0, 1, 0};
    tbl[6]  = '{1'b0,  0,  0, 'h01,  0,  1, 'h43, 0, 1, 0};
    tbl[7]  = '{1'b0,  0,  0, 'h45,  0,  1, 'h45, 1, 1, 0};
    tbl[8]  = '{1'b0,  0,  0, 'h0D,  0,  0, 'h41, 0, 1, 0};
    tbl[9]  = '{1'b1, 79, 44, 'h5A, 79, 44, 'h5A, 0, 1, 0};
    tbl[10] = '{1'b1, 80,  3, 'h51,  0,  4,    0, 0, 1, 1};
    tbl[11] = '{1'b1,  5,  2, 'h71,  5,  2, 'h71, 0, 1, 0};
    tbl[12] = '{1'b1,  0, 45, 'h52,  0, 45,    0, 0, 1, 1};
    tbl[13] = '{1'b0,  0,  0, 'h46,  0,  1, 'h46, 1, 1, 0};

    // Reset values and post-reset clear length
    repeat (3) @(negedge clk_125m);
    chk("rst_cx", int'(cursor_x), 0);
    chk("rst_cy", int'(cursor_y), 0);
    chk("rst_rd", int'(rd_data), 0);
    chk("rst_err", int'(err_range), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(wr_ready), 0);
    rst_n = 1'b1;
    count_ready_low(n);
    chk("reset_clear_len", n, 3600);
    m_clear();
    full_cmp("reset_zero");

    // Table-driven stream and direct writes
    for (int i = 0; i < 14; i++) begin
      push(tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].ch, eg, ee);
      chk($sformatf("vec%0d_err", i), eg, tbl[i].er);
      chk($sformatf("vec%0d_cx", i), int'(cursor_x), tbl[i].cx);
      chk($sformatf("vec%0d_cy", i), int'(cursor_y), tbl[i].cy);
      rd_chk($sformatf("vec%0d_rd", i), tbl[i].rx, tbl[i].ry, tbl[i].rd);
      chk($sformatf("vec%0d_err_once", i), int'(err_range), 0);
    end

    // Same-cycle read/write returns old data, new data next cycle
    @(negedge clk_125m);
    rd_x = XW'(3);
    rd_y = YW'(3);
    push(1'b1, 3, 3, 'h4B, eg, ee);
    chk("rdw_old", int'(rd_data), 0);
    @(posedge clk_125m);
    #1;
    chk("rdw_new", int'(rd_data), 'h4B);

    // Clear wins over a simultaneous write; a second clr_req is ignored
    @(negedge clk_125m);
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_mode  = 1'b1;
    wr_x     = XW'(2);
    wr_y     = YW'(2);
    wr_char  = CW'('h57);
    #1;
    chk("clr_win_ready", int'(wr_ready), 0);
    @(posedge clk_125m);
    #1;
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    chk("clr_busy", int'(busy), 1);
    chk("clr_cx", int'(cursor_x), 0);
    chk("clr_cy", int'(cursor_y), 0);
    m_clear();
    n = 0;
    @(negedge clk_125m);
    while (busy && n < 10000) begin
      clr_req = (n == 100);
      n++;
      @(negedge clk_125m);
    end
    clr_req = 1'b0;
    chk("clr_len", n, 3600);
    rd_chk("clr_win_nowrite", 2, 2, 0);
    rd_chk("clr_zeroed", 3, 3, 0);
    check_cursor("clr");

    // Fill the screen, then one more character forces a scroll
    for (int i = 0; i < 3600; i++) begin
      push(1'b0, 0, 0, 'h41, eg, ee);
    end
    chk("fill_cx", int'(cursor_x), 0);
    chk("fill_cy", int'(cursor_y), 44);
    n = 0;
    @(negedge clk_125m);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk_125m);
    end
    chk("scroll_busy", n, 80);
    push(1'b0, 0, 0, 'h41, eg, ee);
    chk("fill_cx2", int'(cursor_x), 1);
    chk("fill_cy2", int'(cursor_y), 44);
    for (int i = 0; i < COLS; i++) begin
      rd_chk("row44", i, 44, (i == 0) ? 'h41 : 0);
      rd_chk("row0", i, 0, 'h41);
    end

    // Randomized traffic against the logical screen model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        md = 1'b1;
        x  = $urandom_range(0, COLS + 3);
        y  = $urandom_range(0, ROWS + 3);
        c  = $urandom_range('h20, 'h7E);
      end else begin
        md = 1'b0;
        x  = 0;
        y  = 0;
        r2 = $urandom_range(0, 99);
        if (r2 < 12)      c = 'h0A;
        else if (r2 < 16) c = 'h0D;
        else if (r2 < 22) c = 'h08;
        else if (r2 < 25) c = $urandom_range(0, 31);
        else              c = $urandom_range('h20, 'h7E);
      end
      push(md, x, y, c, eg, ee);
      chk("rnd_err", eg, ee);
      check_cursor("rnd");
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        x = $urandom_range(0, COLS);
        y = $urandom_range(0, ROWS);
        rd_chk("rnd_rd", x, y, m_cell(x, y));
      end
    end
    wait_idle();
    full_cmp("final");

    // Reset in the middle of a scroll restarts the full clear
    for (int i = 0; i < ROWS + 1; i++) begin
      push(1'b0, 0, 0, 'h0A, eg, ee);
      if (busy) break;
    end
    chk("scroll_reached", int'(busy), 1);
    repeat (5) @(posedge clk_125m);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_busy", int'(busy), 1);
    chk("rst2_cx", int'(cursor_x), 0);
    chk("rst2_cy", int'(cursor_y), 0);
    repeat (2) @(negedge clk_125m);
    rst_n = 1'b1;
    count_ready_low(n);
    chk("rst2_clear_len", n, 3600);
    m_clear();
    full_cmp("rst2_zero");
    check_cursor("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
